// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] PC8_OFFSET = 32'd8;
  localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode valid/ready handshake carrying the head instruction and its PC.
interface fetch_if;
  import fetch_pkg::*;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc8;

  modport master (
    output instr_valid, instr, instr_pc, instr_pc8,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr, instr_pc, instr_pc8,
    output instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous queue of fetched {pc, instr} entries; flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  fetch_entry_t  mem [QDEPTH];

  assign full  = (count == CW'(QDEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // Storage carries no reset; the head is masked by empty at the top level.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: fetch PC, imem addressing, fetch queue and decode handshake.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  fetch_if.master     dec,
  output logic [31:0] perf_fetch_cnt,
  output logic [15:0] perf_flush_cnt
);

  logic [31:0]  fpc;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t wentry;
  fetch_entry_t head;

  assign imem_a = fpc;
  assign wentry = '{pc: fpc, instr: imem_rd};

  assign dec.instr_valid = !empty;
  assign pop  = dec.instr_valid & dec.instr_ready;
  // A pop frees the slot the same-cycle push lands in, so full+pop still fetches.
  assign push = !redirect_valid & (!full | pop);

  fetch_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wdata   (wentry),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  assign dec.instr     = empty ? '0 : head.instr;
  assign dec.instr_pc  = empty ? '0 : head.pc;
  assign dec.instr_pc8 = empty ? '0 : head.pc + PC8_OFFSET;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fpc <= RESET_PC;
    end else if (redirect_valid) begin
      fpc <= word_align(redirect_pc);
    end else if (push) begin
      fpc <= fpc + PC_STEP;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (push)           perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`else
  assign perf_fetch_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed startup/backpressure/redirect/reset steps, then random traffic,
// all compared against a queue-based model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_W = 32'hFFFF_FFF8;

  logic        clk;
  logic        reset_n;
  logic [31:0] imem_a, imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] perf_fetch_cnt;
  logic [15:0] perf_flush_cnt;

  logic [31:0] imem_a_w, imem_rd_w;
  logic [31:0] perf_fetch_w;
  logic [15:0] perf_flush_w;

  int checks = 0;
  int errors = 0;

  fetch_if dif ();
  fetch_if wif ();

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a < 32'd16) begin
      case (a[3:2])
        2'd0:    return 32'he04f000f;
        2'd1:    return 32'he04f100f;
        2'd2:    return 32'he04f200f;
        default: return 32'he04f300f;
      endcase
    end
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  assign imem_rd   = imem_word(imem_a);
  assign imem_rd_w = imem_word(imem_a_w);
  assign wif.instr_ready = 1'b1;

  fetch_stage #(.RESET_PC(RST_A), .QDEPTH(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_a         (imem_a),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dif),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  fetch_stage #(.RESET_PC(RST_W), .QDEPTH(2)) dut_wrap (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_a         (imem_a_w),
    .imem_rd        (imem_rd_w),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .dec            (wif),
    .perf_fetch_cnt (perf_fetch_w),
    .perf_flush_cnt (perf_flush_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_fetch;
  logic [15:0] m_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Applies one clock of the fetch rules to the model using the inputs currently driven.
  task automatic model_step();
    if (!reset_n) begin
      q.delete();
      m_fpc   = RST_A;
      m_fetch = '0;
      m_flush = '0;
    end else if (redirect_valid) begin
      q.delete();
      m_fpc   = {redirect_pc[31:2], 2'b00};
      m_flush = m_flush + 16'd1;
    end else begin
      if (q.size() > 0 && dif.instr_ready) void'(q.pop_front());
      if (q.size() < 2) begin
        q.push_back('{pc: m_fpc, w: imem_word(m_fpc)});
        m_fpc   = m_fpc + 32'd4;
        m_fetch = m_fetch + 32'd1;
      end
    end
  endtask

  task automatic check_all();
    logic        v;
    logic [31:0] ei, ep;
    v  = (q.size() > 0);
    ei = v ? q[0].w  : 32'h0;
    ep = v ? q[0].pc : 32'h0;
    chk("model_valid", 32'(dif.instr_valid), 32'(v));
    chk("model_instr", dif.instr, ei);
    chk("model_pc", dif.instr_pc, ep);
    chk("model_pc8", dif.instr_pc8, v ? ep + 32'd8 : 32'h0);
    chk("model_imem_a", imem_a, m_fpc);
`ifdef FETCH_PERF_EN
    chk("model_perf_fetch", perf_fetch_cnt, m_fetch);
    chk("model_perf_flush", 32'(perf_flush_cnt), 32'(m_flush));
`else
    chk("model_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("model_perf_flush", 32'(perf_flush_cnt), 32'h0);
`endif
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] tgt;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dif.instr_ready = 1'b0;

    // Reset and startup under backpressure
    repeat (3) cyc();
    chk("rst_valid", 32'(dif.instr_valid), 32'h0);
    chk("rst_instr", dif.instr, 32'h0);
    chk("rst_pc8", dif.instr_pc8, 32'h0);
    chk("rst_imem_a", imem_a, 32'h0);
    chk("rst_imem_a_wrap", imem_a_w, RST_W);
    reset_n = 1'b1;
    cyc();
    chk("first_instr", dif.instr, 32'he04f000f);
    chk("first_pc", dif.instr_pc, 32'h0);
    chk("first_pc8", dif.instr_pc8, 32'h8);
    chk("wrap_pc0", wif.instr_pc, 32'hFFFF_FFF8);
    cyc();
    chk("wrap_pc1", wif.instr_pc, 32'hFFFF_FFFC);
    chk("wrap_pc8", wif.instr_pc8, 32'h0000_0004);
    cyc();
    chk("wrap_pc2", wif.instr_pc, 32'h0000_0000);
    repeat (3) cyc();
    chk("stall_imem_a", imem_a, 32'h8);
    chk("stall_head", dif.instr, 32'he04f000f);
    dif.instr_ready = 1'b1;
    cyc();
    chk("drain_pc4", dif.instr_pc, 32'h4);
    chk("drain_instr4", dif.instr, 32'he04f100f);
    cyc();
    chk("drain_pc8", dif.instr_pc, 32'h8);

    // Redirect while valid and ready
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1E;
    cyc();
    redirect_valid = 1'b0;
    chk("redir_valid", 32'(dif.instr_valid), 32'h0);
    chk("redir_imem_a", imem_a, 32'h1C);
    cyc();
    chk("redir_pc", dif.instr_pc, 32'h1C);

    // Redirect while full with no ready
    dif.instr_ready = 1'b0;
    repeat (2) cyc();
    tgt = $urandom;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    cyc();
    redirect_valid = 1'b0;
    chk("fullredir_valid", 32'(dif.instr_valid), 32'h0);
    chk("fullredir_imem_a", imem_a, tgt & 32'hFFFF_FFFC);
    cyc();
    chk("fullredir_pc", dif.instr_pc, tgt & 32'hFFFF_FFFC);

    // Counters over 10 pushes and 2 redirects, then a one-cycle reset
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    dif.instr_ready = 1'b1;
    repeat (6) cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cyc();
    redirect_valid = 1'b0;
    repeat (4) cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cyc();
    redirect_valid = 1'b0;
`ifdef FETCH_PERF_EN
    chk("perf_fetch10", perf_fetch_cnt, 32'd10);
    chk("perf_flush2", 32'(perf_flush_cnt), 32'd2);
`else
    chk("perf_fetch_off", perf_fetch_cnt, 32'd0);
    chk("perf_flush_off", 32'(perf_flush_cnt), 32'd0);
`endif
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("mid_rst_fetch", perf_fetch_cnt, 32'd0);
    chk("mid_rst_flush", 32'(perf_flush_cnt), 32'd0);
    chk("mid_rst_valid", 32'(dif.instr_valid), 32'h0);
    chk("mid_rst_imem_a", imem_a, RST_A);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      dif.instr_ready = ($urandom_range(0, 3) != 0);
      redirect_valid  = ($urandom_range(0, 15) == 0);
      redirect_pc     = $urandom;
      reset_n         = ($urandom_range(0, 99) != 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the ARM core, directly upstream of the combinational instruction memory (imem).
- Holds the fetch PC, drives the imem word address and captures each returned word with its PC into a 2-entry queue.
- Presents fetched instructions to decode over a valid/ready handshake.
- Decode/execute may redirect fetch for a taken branch; the queue is flushed on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; low 2 bits must be 0.
- QDEPTH, 2, instruction queue entries; power of two, at least 2.

Ports:
- clk  in  1  single core clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset; sampled on posedge clk.
- imem_a  out  32  byte address to imem; always equals fetch PC (fpc); bits [1:0] are always 0.
- imem_rd  in  32  instruction word returned combinationally by imem for imem_a in the same cycle.
- redirect_valid  in  1  one-cycle pulse requesting fetch restart.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- instr_valid  out  1  queue head is valid.
- instr_ready  in  1  decode accepts the head this cycle.
- instr  out  32  head instruction word.
- instr_pc  out  32  head instruction address.
- instr_pc8  out  32  instr_pc + 8 (ARM PC-read value), modulo 2^32.
- perf_fetch_cnt  out  32  number of words pushed into the queue (see Optional Feature).
- perf_flush_cnt  out  16  number of redirects taken (see Optional Feature).

Behaviour:
- Reset: while reset_n=0 at posedge, fpc<=RESET_PC, queue count<=0, read/write pointers<=0, perf counters<=0. Outputs after reset: instr_valid=0; instr, instr_pc and instr_pc8 are 0; imem_a=RESET_PC.
- Reset asserted mid-operation discards all queued entries and any pending redirect.
- pop = instr_valid & instr_ready.
- push = !redirect_valid & ((count<QDEPTH) | pop). Pop frees a slot for a push in the same cycle, so push and pop while full is legal.
- On push: the entry {fpc, imem_rd} is written at the tail, and fpc<=fpc+4. The PC wraps 32'hFFFF_FFFC -> 0.
- No push: fpc holds. imem_a stays stable while stalled.
- Redirect has priority over push and pop in the same cycle:
  - count<=0, pointers<=0.
  - fpc<=redirect_pc & ~32'h3.
  - no push that cycle; any pop is ignored as a flush.
  - Decode must treat a head shown in the redirect cycle as killed.
- Latency: a word fetched while fpc=X appears at the head no earlier than the next cycle.
  - First instr_valid=1 occurs in the 2nd cycle after reset_n rises.
  - After a redirect, first valid instruction at the target appears 2 cycles after the redirect cycle.
- With continuous ready and no redirect: throughput is 1 instruction per cycle, and instr_pc increments by 4 each cycle.
- Head outputs are stable while instr_valid=1 and instr_ready=0.
- The queue never overflows or underflows. Pop with count=0 is impossible because instr_valid=0.
- Count width is clog2(QDEPTH)+1. Pointers wrap modulo QDEPTH.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - perf_fetch_cnt increments by 1 on each push.
  - perf_flush_cnt increments by 1 on each redirect.
  - Both wrap at their width; both are cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are generated. The port list is identical either way.

Decomposition:
- Package fetch_pkg holds:
  - fetch_entry_t: packed struct {logic [31:0] pc; logic [31:0] instr;}
  - PC_STEP=32'd4, PC8_OFFSET=32'd8, WORD_MASK=32'hFFFF_FFFC.
- Sub-module fetch_fifo: synchronous fetch_entry_t FIFO, depth QDEPTH, with push, pop, flush, full, empty and head ports; flush has priority.
- fetch_stage holds the PC logic, the handshake and the perf counters.

Test Plan:
- Reset/startup: imem model loaded with words[0..3]=e04f000f, e04f100f, e04f200f, e04f300f; reset_n low 3 cycles, then high, ready=1 -> cycle 1: instr_valid=0, imem_a=0; cycle 2: instr=e04f000f, instr_pc=0, instr_pc8=8; then e04f100f at pc=4 and onward, one per cycle.
- Backpressure: ready=0 for 5 cycles after first valid -> queue fills to 2; imem_a holds at 8; head stays e04f000f/pc 0. Ready=1 -> pcs 0, 4, 8 delivered in order with no loss or duplicate.
- Redirect: redirect_valid=1 with redirect_pc=32'h1E, same cycle as ready=1 and valid=1 -> queue empties; next cycle imem_a=32'h1C; 2 cycles later instr_pc=32'h1C.
- Redirect while full with ready=0: queue cleared; old entries never reappear; fpc equals the target.
- Wrap: RESET_PC=32'hFFFF_FFF8 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; instr_pc8 for FFFF_FFFC = 0000_0004.
- Reset mid-stream plus FETCH_PERF_EN: after 10 pushes and 2 redirects, perf_fetch_cnt=10 and perf_flush_cnt=2. Reset_n low 1 cycle -> counters 0, instr_valid 0, imem_a=RESET_PC. Without the macro, both counters always read 0.
